mem_arbiter: RTL and testbench

- Two-master front end for the memory bus: arbitrates instruction-fetch (IFU) reads and load/store (LSU) requests onto the single-request memory bus port.
- Keeps at most one transaction outstanding and routes the response back to the master that issued it.
- Bounds LSU priority with a fairness counter and enforces a response watchdog so an unmapped region cannot hang the core.
- Sits directly upstream of memory_bus; its mem_* outputs connect straight to memory_bus's mem_* inputs.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the two-master memory bus arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates IFU reads and LSU requests onto the single-outstanding memory bus
// port, with bounded LSU priority and a response watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LSU_MAX_STREAK = 4,
  parameter int RSP_TIMEOUT    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rsp_valid,
  output logic              ifu_rsp_err,
  output logic [DATA_W-1:0] ifu_data_r,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data_w,
  input  logic [STRB_W-1:0] lsu_wstrb,
  output logic              lsu_rsp_valid,
  output logic              lsu_rsp_err,
  output logic [DATA_W-1:0] lsu_data_r,
  output logic              mem_mstReq_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_w,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [DATA_W-1:0] mem_data_r,
  input  logic              mem_slvRsp_valid
);

  localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
  localparam int STK_W = $clog2(LSU_MAX_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_TIMEOUT);
  localparam logic [STK_W-1:0] STK_MAX = STK_W'(LSU_MAX_STREAK);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  streak_q, streak_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic inWait, timedOut, rspHit, rspFire, ifuWins, accept, grantIfu, grantLsu;

  // A reset cycle suppresses every pulse, so a discarded transaction never answers.
  assign inWait   = (state_q == WAIT) && !RST;
  assign timedOut = inWait && (cnt_q == CNT_MAX);
  assign rspHit   = inWait && !timedOut && mem_slvRsp_valid;
  assign rspFire  = rspHit || timedOut;
  assign ifuWins  = ifu_req_valid && (!lsu_req_valid || (streak_q == STK_MAX));
  assign accept   = (ifu_req_valid || lsu_req_valid) && !RST &&
                    ((state_q == IDLE) || rspHit);
  assign grantIfu = accept && ifuWins;
  assign grantLsu = accept && !ifuWins;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    streak_d = streak_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (timedOut)    state_d = IDLE;
        else if (rspHit) state_d = accept ? ISSUE : IDLE;
        else             cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // The streak only grows while the IFU is actually being held off.
    if (grantLsu) begin
      streak_d = !ifu_req_valid ? '0 :
                 (streak_q == STK_MAX) ? streak_q : streak_q + STK_W'(1);
      owner_d  = OWN_LSU;
      addr_d   = lsu_addr;
      wdata_d  = lsu_data_w;
      wstrb_d  = lsu_wstrb;
    end else if (grantIfu) begin
      streak_d = '0;
      owner_d  = OWN_IFU;
      addr_d   = ifu_addr;
      wdata_d  = '0;
      wstrb_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign ifu_req_ready    = grantIfu;
  assign lsu_req_ready    = grantLsu;
  assign mem_mstReq_valid = (state_q == ISSUE) && !RST;
  assign mem_addr         = mem_mstReq_valid ? addr_q  : '0;
  assign mem_data_w       = mem_mstReq_valid ? wdata_q : '0;
  assign mem_wstrb        = mem_mstReq_valid ? wstrb_q : '0;

  assign ifu_rsp_valid = rspFire && (owner_q == OWN_IFU);
  assign lsu_rsp_valid = rspFire && (owner_q == OWN_LSU);
  assign ifu_rsp_err   = ifu_rsp_valid && timedOut;
  assign lsu_rsp_err   = lsu_rsp_valid && timedOut;
  assign ifu_data_r    = (ifu_rsp_valid && rspHit) ? mem_data_r : '0;
  assign lsu_data_r    = (lsu_rsp_valid && rspHit) ? mem_data_r : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected bus requests and
// responses, a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [63:0] ifu_addr = '0;
  logic        ifu_rsp_valid, ifu_rsp_err;
  logic [63:0] ifu_data_r;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [63:0] lsu_addr = '0, lsu_data_w = '0;
  logic [7:0]  lsu_wstrb = '0;
  logic        lsu_rsp_valid, lsu_rsp_err;
  logic [63:0] lsu_data_r;
  logic        mem_mstReq_valid;
  logic [63:0] mem_addr, mem_data_w;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_data_r = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        mem_slvRsp_valid = 1'b0;

  mem_arbiter #(.LSU_MAX_STREAK(4), .RSP_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_data_r(ifu_data_r),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_data_w(lsu_data_w), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .lsu_data_r(lsu_data_r),
    .mem_mstReq_valid(mem_mstReq_valid), .mem_addr(mem_addr), .mem_data_w(mem_data_w),
    .mem_wstrb(mem_wstrb), .mem_data_r(mem_data_r), .mem_slvRsp_valid(mem_slvRsp_valid)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    int          cyc;
    int          lat;
  } busExp_t;

  typedef struct {
    logic        own;
    logic [63:0] data;
    logic        err;
    int          cyc;
  } rspExp_t;

  busExp_t     busQ[$];
  rspExp_t     rspQ[$];
  busExp_t     mBe;
  rspExp_t     mRe;
  int          vecCount = 0;
  int          missCount = 0;
  int          cyc = 0;
  int          rspCnt = 0;
  logic [63:0] rspAddr = '0;
  bit          fairMode = 1'b0;
  int          lastBus = -1;
  int          gIdx = 0;
  bit          expSeq [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [63:0] memFn(input logic [63:0] a);
    if (a == 64'h8000_0008) return 64'hDEAD_BEEF_CAFE_F00D;
    return {~a[31:0], a[31:0] ^ 32'h5A5A_A5A5};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_memValid"}, 64'(mem_mstReq_valid), 64'h0);
    checkOutput({tag, "_memAddr"}, mem_addr, 64'h0);
    checkOutput({tag, "_memWdata"}, mem_data_w, 64'h0);
    checkOutput({tag, "_memWstrb"}, {56'h0, mem_wstrb}, 64'h0);
    checkOutput({tag, "_readies"}, {62'h0, ifu_req_ready, lsu_req_ready}, 64'h0);
    checkOutput({tag, "_rspValid"}, {62'h0, ifu_rsp_valid, lsu_rsp_valid}, 64'h0);
    checkOutput({tag, "_rspErr"}, {62'h0, ifu_rsp_err, lsu_rsp_err}, 64'h0);
    checkOutput({tag, "_ifuData"}, ifu_data_r, 64'h0);
    checkOutput({tag, "_lsuData"}, lsu_data_r, 64'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  // kind: 0 normal response after lat cycles, 1 timeout error, 2 no response.
  task automatic applyStimulus(input bit isLsu, input logic [63:0] a, input logic [63:0] d,
                               input logic [7:0] s, input int lat, input int kind,
                               input bit keep, output int accCyc, output int waited);
    busExp_t be;
    rspExp_t re;
    bit got = 1'b0;
    if (isLsu) begin
      lsu_req_valid = 1'b1; lsu_addr = a; lsu_data_w = d; lsu_wstrb = s;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = a;
    end
    waited = 0;
    accCyc = -1;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge CLK);
      waited++;
      if (isLsu ? lsu_req_ready : ifu_req_ready) got = 1'b1;
    end
    if (!got) begin
      checkOutput(isLsu ? "lsuReadyTimeout" : "ifuReadyTimeout", 64'h0, 64'h1);
    end else begin
      accCyc   = cyc;
      be.addr  = a;
      be.wdata = isLsu ? d : 64'h0;
      be.strb  = isLsu ? s : 8'h0;
      be.cyc   = cyc + 1;
      be.lat   = lat;
      busQ.push_back(be);
      re.own = isLsu;
      if (kind == 0) begin
        re.data = memFn(a); re.err = 1'b0; re.cyc = cyc + 1 + lat;
        rspQ.push_back(re);
      end else if (kind == 1) begin
        re.data = 64'h0; re.err = 1'b1; re.cyc = cyc + 2 + 16;
        rspQ.push_back(re);
      end
    end
    @(posedge CLK);
    #1;
    if (!keep) begin
      if (isLsu) lsu_req_valid = 1'b0;
      else       ifu_req_valid = 1'b0;
    end
  endtask

  // Memory model: answers lat cycles after a request; garbage data otherwise.
  initial forever begin
    @(posedge CLK);
    #1;
    if (rspCnt == 1) begin
      mem_slvRsp_valid = 1'b1;
      mem_data_r       = memFn(rspAddr);
      rspCnt           = 0;
    end else begin
      mem_slvRsp_valid = 1'b0;
      mem_data_r       = 64'hFFFF_FFFF_FFFF_FFFF;
      if (rspCnt > 1) rspCnt--;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (mem_mstReq_valid) begin
      if (busQ.size() == 0) checkOutput("busUnexpected", 64'h1, 64'h0);
      else begin
        mBe = busQ.pop_front();
        checkOutput("busAddr", mem_addr, mBe.addr);
        checkOutput("busWdata", mem_data_w, mBe.wdata);
        checkOutput("busWstrb", {56'h0, mem_wstrb}, {56'h0, mBe.strb});
        checkOutput("busCycle", 64'(cyc), 64'(mBe.cyc));
        if (mBe.lat > 0) begin
          rspCnt  = mBe.lat;
          rspAddr = mBe.addr;
        end
      end
      if (fairMode) begin
        if (lastBus >= 0) checkOutput("busGap", 64'(cyc - lastBus), 64'd2);
        lastBus = cyc;
      end
    end
    if (ifu_rsp_valid && lsu_rsp_valid) checkOutput("rspBoth", 64'h1, 64'h0);
    if (ifu_rsp_valid || lsu_rsp_valid) begin
      if (rspQ.size() == 0) checkOutput("rspUnexpected", 64'h1, 64'h0);
      else begin
        mRe = rspQ.pop_front();
        checkOutput("rspOwner", 64'(lsu_rsp_valid), 64'(mRe.own));
        checkOutput("rspData", lsu_rsp_valid ? lsu_data_r : ifu_data_r, mRe.data);
        checkOutput("rspErr", 64'(lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err), 64'(mRe.err));
        checkOutput("rspCycle", 64'(cyc), 64'(mRe.cyc));
      end
    end
    if (!ifu_rsp_valid) checkOutput("ifuDataIdle", ifu_data_r, 64'h0);
    if (!lsu_rsp_valid) checkOutput("lsuDataIdle", lsu_data_r, 64'h0);
    if (fairMode && (ifu_req_ready || lsu_req_ready) && gIdx < 10) begin
      checkOutput("grantSeq", 64'(lsu_req_ready), 64'(expSeq[gIdx]));
      gIdx++;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: time limit reached, observed %0d vectors, expected completion", vecCount);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int acc, w, acc2, w2;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkAllZero("inReset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkAllZero("afterReset");
    @(posedge CLK);
    #1;

    $display("[TB] single LSU write");
    applyStimulus(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 1, 0, 1'b0, acc, w);
    checkOutput("lsuWriteWait", 64'(w), 64'd1);
    idle(3);

    $display("[TB] IFU read");
    applyStimulus(1'b0, 64'h8000_0008, 64'h0, 8'h0, 1, 0, 1'b0, acc, w);
    idle(3);

    $display("[TB] fairness with both masters valid");
    fairMode = 1'b1;
    lastBus  = -1;
    gIdx     = 0;
    fork
      begin
        int a1, w1;
        for (int i = 0; i < 8; i++)
          applyStimulus(1'b1, 64'h1000 + 64'(i * 8), {32'hA000_0000, 32'(i)},
                        (i % 2 == 1) ? 8'h0F : 8'h00, 1, 0, (i < 7), a1, w1);
      end
      begin
        int a2, wi;
        for (int j = 0; j < 2; j++)
          applyStimulus(1'b0, 64'h2000 + 64'(j * 4), 64'h0, 8'h0, 1, 0, (j < 1), a2, wi);
      end
    join
    idle(3);
    fairMode = 1'b0;
    checkOutput("grantCount", 64'(gIdx), 64'd10);

    $display("[TB] response timeout");
    applyStimulus(1'b1, 64'h9000_0000, 64'h0, 8'h00, 0, 1, 1'b0, acc, w);
    while (cyc < acc + 18) @(negedge CLK);
    rspCnt  = 1;
    rspAddr = 64'h9000_0000;
    @(negedge CLK);
    checkOutput("lateRspLsu", 64'(lsu_rsp_valid), 64'h0);
    checkOutput("lateRspIfu", 64'(ifu_rsp_valid), 64'h0);
    checkOutput("lateRspBus", 64'(mem_mstReq_valid), 64'h0);
    idle(2);

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 64'h8000_0100, 64'hCAFE_0000_0000_BABE, 8'h0F, 0, 2, 1'b0, acc, w);
    idle(2);
    RST = 1'b1;
    @(negedge CLK);
    checkAllZero("rstMid");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkAllZero("afterMidRst");
    @(posedge CLK);
    #1;
    applyStimulus(1'b1, 64'h8000_0200, 64'h0102_0304_0506_0708, 8'hF0, 1, 0, 1'b0, acc, w);
    checkOutput("postRstWait", 64'(w), 64'd1);
    idle(3);

    $display("[TB] LSU held across ISSUE/WAIT");
    applyStimulus(1'b0, 64'h8000_0300, 64'h0, 8'h0, 2, 0, 1'b0, acc, w);
    applyStimulus(1'b1, 64'h8000_0400, 64'h5555_AAAA_5555_AAAA, 8'h3C, 1, 0, 1'b0, acc2, w2);
    checkOutput("holdWaited", 64'(w2), 64'd3);
    checkOutput("holdAcceptCycle", 64'(acc2), 64'(acc + 3));

    idle(25);
    checkOutput("busQDrained", 64'(busQ.size()), 64'h0);
    checkOutput("rspQDrained", 64'(rspQ.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
